// File: rtl/cell_addr_to_coord.sv
// Converts a flat board cell address into (x, y) = (addr / BOARD_N, addr % BOARD_N)
// by repeated subtraction; out-of-board addresses are reported through out_oob.
module cell_addr_to_coord #(
    parameter int unsigned BOARD_N = 6,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned COORD_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_oob
);

    localparam int unsigned CELLS = BOARD_N * BOARD_N;
    // One extra bit so the cell count itself never truncates at ADDR_W
    localparam logic [ADDR_W:0]   CELLS_W = (ADDR_W + 1)'(CELLS);
    localparam logic [ADDR_W-1:0] DIVISOR = ADDR_W'(BOARD_N);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t               state, state_d;
    logic [ADDR_W-1:0]    rem, rem_d;
    logic [COORD_W-1:0]   quo, quo_d;
    logic                 oob, oob_d;
    logic                 out_valid_d;
    logic [COORD_W-1:0]   out_x_d, out_y_d;
    logic                 out_oob_d;

    assign in_ready = (state == IDLE) && !rst;

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= '0;
            quo       <= '0;
            oob       <= 1'b0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_oob   <= 1'b0;
        end else begin
            state     <= state_d;
            rem       <= rem_d;
            quo       <= quo_d;
            oob       <= oob_d;
            out_valid <= out_valid_d;
            out_x     <= out_x_d;
            out_y     <= out_y_d;
            out_oob   <= out_oob_d;
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_d     = state;
        rem_d       = rem;
        quo_d       = quo;
        oob_d       = oob;
        out_valid_d = out_valid;
        out_x_d     = out_x;
        out_y_d     = out_y;
        out_oob_d   = out_oob;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    rem_d   = in_addr;
                    quo_d   = '0;
                    oob_d   = ({1'b0, in_addr} >= CELLS_W);
                    state_d = DIV;
                end
            end
            DIV: begin
                if (oob) begin
                    out_x_d     = '0;
                    out_y_d     = '0;
                    out_oob_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (rem >= DIVISOR) begin
                    rem_d = rem - DIVISOR;
                    quo_d = quo + COORD_W'(1);
                end else begin
                    // rem < BOARD_N here, so the narrowing keeps every set bit
                    out_x_d     = quo;
                    out_y_d     = rem[COORD_W-1:0];
                    out_oob_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cell_addr_to_coord.sv
// Directed bench for cell_addr_to_coord: reset, corners, out-of-range,
// backpressure, mid-operation reset and a full address sweep.
module tb_cell_addr_to_coord;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_addr;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_x;
    logic [2:0] out_y;
    logic       out_oob;

    int n_checks = 0;
    int n_fail   = 0;

    cell_addr_to_coord #(
        .BOARD_N(6),
        .ADDR_W (6),
        .COORD_W(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_oob  (out_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present addr until accepted; returns 1 ns after the accepting edge
    task automatic accept(input logic [5:0] addr);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_addr  = addr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the result, check it, optionally stall, then check the handoff
    task automatic wait_result(input string tag, input int exp_lat, input logic [2:0] ex,
                               input logic [2:0] ey, input logic eo, input int stalls);
        int lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            lat = i;
            if (out_valid) break;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_x"}, 32'(out_x), 32'(ex));
        check({tag, "_y"}, 32'(out_y), 32'(ey));
        check({tag, "_oob"}, 32'(out_oob), 32'(eo));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        if (stalls > 0) begin
            out_ready = 1'b0;
            for (int s = 0; s < stalls; s++) begin
                @(posedge clk);
                #1;
                check({tag, "_hold"}, {29'd0, out_valid, out_oob, in_ready},
                      {29'd0, 1'b1, eo, 1'b0});
                check({tag, "_hold_xy"}, 32'({out_x, out_y}), 32'({ex, ey}));
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_handoff_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0, expected 1");
        $fatal(1, "simulation timed out");
    end

    initial begin
        int unsigned a;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_addr   = 6'd7;
        out_ready = 1'b1;

        // Reset held for two edges with a pending request
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_xy", 32'({out_x, out_y}), 32'd0);
        check("rst_oob", 32'(out_oob), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("post_rst_no_out", 32'(out_valid), 32'd0);

        // Corners
        accept(6'd0);  wait_result("a0", 1, 3'd0, 3'd0, 1'b0, 0);
        accept(6'd35); wait_result("a35", 6, 3'd5, 3'd5, 1'b0, 0);
        accept(6'd5);  wait_result("a5", 1, 3'd0, 3'd5, 1'b0, 0);
        accept(6'd6);  wait_result("a6", 2, 3'd1, 3'd0, 1'b0, 0);

        // Out of range, then back in range
        accept(6'd36); wait_result("a36", 1, 3'd0, 3'd0, 1'b1, 0);
        accept(6'd63); wait_result("a63", 1, 3'd0, 3'd0, 1'b1, 0);
        accept(6'd23); wait_result("a23", 4, 3'd3, 3'd5, 1'b0, 0);

        // Backpressure with a competing request presented the whole time
        accept(6'd17);
        in_valid = 1'b1;
        in_addr  = 6'd9;
        wait_result("bp17", 3, 3'd2, 3'd5, 1'b0, 5);
        accept(6'd9);
        wait_result("bp9", 2, 3'd1, 3'd3, 1'b0, 0);

        // Reset two edges after accepting addr 35
        accept(6'd35);
        @(posedge clk);
        #1;
        check("mid_no_out1", 32'(out_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_no_out2", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("mid_quiet", 32'(out_valid), 32'd0);
        end
        accept(6'd12);
        wait_result("a12", 3, 3'd2, 3'd0, 1'b0, 0);

        // Full sweep with random output stalls
        for (int i = 0; i < 64; i++) begin
            a = i;
            accept(6'(a));
            if (a < 36)
                wait_result("sweep", int'(a / 6) + 1, 3'(a / 6), 3'(a % 6), 1'b0,
                            int'($urandom_range(0, 3)));
            else
                wait_result("sweep_oob", 1, 3'd0, 3'd0, 1'b1, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
